// File: rtl/ds18b20_pkg.sv
// Shared state encodings and raw-value limits
// for the DS18B20 temperature poller.
package ds18b20_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CONV,
        HUND,
        TENS,
        OUT
    } pollState_t;

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_HUND,
        BCD_TENS
    } bcdPhase_t;

    localparam logic [15:0] DS_POR_RAW = 16'h0550;
    localparam logic [15:0] DS_MIN_RAW = 16'hFC90;
    localparam logic [15:0] DS_MAX_RAW = 16'h07D0;

    // Low 11 bits of |raw|; upper bits never matter inside the legal range.
    function automatic logic [10:0] dsMagnitude(
        input logic       neg,
        input logic [10:0] bits
    );
        return neg ? (~bits + 11'd1) : bits;
    endfunction

    function automatic logic [3:0] dsTenths(input logic [3:0] frac);
        return 4'(({4'd0, frac} * 8'd10) >> 4);
    endfunction

endpackage

// File: rtl/ds18b20_temp_poller_bcd.sv
// Iterative hundreds/tens/units split of a 7-bit integer
// by repeated subtraction, one step per cycle.
module ds_bcd_digits
    import ds18b20_pkg::*;
(
    input  logic       CLK_10MHZ,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] intPart,
    output logic       hundreds,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       done
);

    bcdPhase_t  phase;
    bcdPhase_t  phaseNext;
    logic [6:0] rem;
    logic [6:0] remNext;
    logic       hundNext;
    logic [3:0] tensNext;

    always_ff @(posedge CLK_10MHZ) begin
        if (reset) begin
            phase    <= BCD_IDLE;
            rem      <= 7'd0;
            hundreds <= 1'b0;
            tens     <= 4'd0;
        end else begin
            phase    <= phaseNext;
            rem      <= remNext;
            hundreds <= hundNext;
            tens     <= tensNext;
        end
    end

    always_comb begin
        phaseNext = phase;
        remNext   = rem;
        hundNext  = hundreds;
        tensNext  = tens;
        if (start) begin
            phaseNext = BCD_HUND;
            remNext   = intPart;
            hundNext  = 1'b0;
            tensNext  = 4'd0;
        end else begin
            unique case (phase)
                BCD_HUND: begin
                    if (rem >= 7'd100) begin
                        hundNext = 1'b1;
                        remNext  = rem - 7'd100;
                    end
                    phaseNext = BCD_TENS;
                end
                BCD_TENS: begin
                    if (rem >= 7'd10) begin
                        tensNext = tens + 4'd1;
                        remNext  = rem - 7'd10;
                    end else begin
                        phaseNext = BCD_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign units = rem[3:0];
    assign done  = (phase == BCD_TENS) && (rem < 7'd10);

endmodule

// File: rtl/ds18b20_temp_poller.sv
// Periodic DS18B20 poll: start pulse, wait for the reading,
// validate it and hold the last good value as sign + BCD digits.
module ds18b20_temp_poller
    import ds18b20_pkg::*;
#(
    parameter int          POLL_PERIOD = 10_000_000,
    parameter int          TIMEOUT     = 12_000_000,
    parameter logic [15:0] MIN_RAW     = DS_MIN_RAW,
    parameter logic [15:0] MAX_RAW     = DS_MAX_RAW
) (
    input  logic        CLK_10MHZ,
    input  logic        reset,
    input  logic        enable,
    output logic        start,
    input  logic [15:0] temperature,
    input  logic        temp_strobe,
    output logic [15:0] temp_raw,
    output logic        temp_sign,
    output logic        temp_hundreds,
    output logic [3:0]  temp_tens,
    output logic [3:0]  temp_units,
    output logic [3:0]  temp_tenths,
    output logic        temp_valid,
    output logic        temp_update,
    output logic        timeout_err,
    output logic        range_err
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    pollState_t    state;
    pollState_t    stateNext;
    logic [PW-1:0] pollCnt;
    logic [TW-1:0] waitCnt;
    logic [15:0]   rawQ;
    logic          porSeen;
    logic [10:0]   mag;
    logic          outOfRange;
    logic          isPorValue;
    logic          bcdStart;
    logic          bcdDone;
    logic          bcdHund;
    logic [3:0]    bcdTens;
    logic [3:0]    bcdUnits;
    logic          setTimeout;
    logic          setRange;
    logic          setPor;
    logic          loadOut;

    assign mag        = dsMagnitude(rawQ[15], rawQ[10:0]);
    assign outOfRange = ($signed(rawQ) < $signed(MIN_RAW))
                     || ($signed(rawQ) > $signed(MAX_RAW));
    assign isPorValue = (rawQ == DS_POR_RAW) && !porSeen;
    assign start       = (state == START);
    assign temp_update = (state == OUT);

    ds_bcd_digits uBcd (
        .CLK_10MHZ (CLK_10MHZ),
        .reset     (reset),
        .start     (bcdStart),
        .intPart   (mag[10:4]),
        .hundreds  (bcdHund),
        .tens      (bcdTens),
        .units     (bcdUnits),
        .done      (bcdDone)
    );

    always_comb begin
        stateNext  = state;
        bcdStart   = 1'b0;
        setTimeout = 1'b0;
        setRange   = 1'b0;
        setPor     = 1'b0;
        loadOut    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && (pollCnt == POLL_LAST)) begin
                    stateNext = START;
                end
            end
            START: stateNext = WAIT;
            WAIT: begin
                if (temp_strobe) begin
                    stateNext = CONV;
                end else if (waitCnt == WAIT_LAST) begin
                    setTimeout = 1'b1;
                    stateNext  = IDLE;
                end
            end
            CONV: begin
                if (outOfRange) begin
                    setRange  = 1'b1;
                    stateNext = IDLE;
                end else if (isPorValue) begin
                    // Power-on default word: drop it silently once.
                    setPor    = 1'b1;
                    stateNext = IDLE;
                end else begin
                    bcdStart  = 1'b1;
                    stateNext = HUND;
                end
            end
            HUND: stateNext = TENS;
            TENS: begin
                if (bcdDone) begin
                    loadOut   = 1'b1;
                    stateNext = OUT;
                end
            end
            OUT: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (reset) begin
            state         <= IDLE;
            pollCnt       <= '0;
            waitCnt       <= '0;
            rawQ          <= 16'd0;
            porSeen       <= 1'b0;
            temp_raw      <= 16'd0;
            temp_sign     <= 1'b0;
            temp_hundreds <= 1'b0;
            temp_tens     <= 4'd0;
            temp_units    <= 4'd0;
            temp_tenths   <= 4'd0;
            temp_valid    <= 1'b0;
            timeout_err   <= 1'b0;
            range_err     <= 1'b0;
        end else begin
            state <= stateNext;

            if ((state != IDLE) || !enable) begin
                pollCnt <= '0;
            end else if (pollCnt != POLL_LAST) begin
                pollCnt <= pollCnt + 1'b1;
            end

            if (state != WAIT) begin
                waitCnt <= '0;
            end else if (waitCnt != WAIT_LAST) begin
                waitCnt <= waitCnt + 1'b1;
            end

            if ((state == WAIT) && temp_strobe) begin
                rawQ <= temperature;
            end

            if (setPor) begin
                porSeen <= 1'b1;
            end
            if (setTimeout) begin
                timeout_err <= 1'b1;
            end
            if (setRange) begin
                range_err <= 1'b1;
            end

            // Digits land together with the OUT cycle that pulses temp_update.
            if (loadOut) begin
                temp_raw      <= rawQ;
                temp_sign     <= rawQ[15];
                temp_hundreds <= bcdHund;
                temp_tens     <= bcdTens;
                temp_units    <= bcdUnits;
                temp_tenths   <= dsTenths(mag[3:0]);
                temp_valid    <= 1'b1;
                timeout_err   <= 1'b0;
                range_err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ds18b20_temp_poller.sv
// Directed bench for ds18b20_temp_poller with a simple
// 1-Wire controller model that answers 20 cycles after start.
module tb_ds18b20_temp_poller;

    localparam int P      = 100;
    localparam int TO     = 50;
    localparam int RESP   = 20;
    localparam int K_OK   = 0;
    localparam int K_RNG  = 1;
    localparam int K_DISC = 2;

    typedef struct {
        logic [15:0] raw;
        int          kind;
        logic        sign;
        logic        hund;
        logic [3:0]  tens;
        logic [3:0]  units;
        logic [3:0]  tenths;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic [15:0] temperature;
    logic        temp_strobe;
    logic [15:0] temp_raw;
    logic        temp_sign;
    logic        temp_hundreds;
    logic [3:0]  temp_tens;
    logic [3:0]  temp_units;
    logic [3:0]  temp_tenths;
    logic        temp_valid;
    logic        temp_update;
    logic        timeout_err;
    logic        range_err;

    int nChecks = 0;
    int nFails  = 0;

    logic        hValid;
    logic        hSign;
    logic        hHund;
    logic [3:0]  hTens;
    logic [3:0]  hUnits;
    logic [3:0]  hTenths;
    logic [15:0] hRaw;
    logic        hRange;
    logic        hTimeout;

    vec_t vecs[14];

    always #50 clk = ~clk;

    ds18b20_temp_poller #(
        .POLL_PERIOD (P),
        .TIMEOUT     (TO)
    ) dut (
        .CLK_10MHZ     (clk),
        .reset         (reset),
        .enable        (enable),
        .start         (start),
        .temperature   (temperature),
        .temp_strobe   (temp_strobe),
        .temp_raw      (temp_raw),
        .temp_sign     (temp_sign),
        .temp_hundreds (temp_hundreds),
        .temp_tens     (temp_tens),
        .temp_units    (temp_units),
        .temp_tenths   (temp_tenths),
        .temp_valid    (temp_valid),
        .temp_update   (temp_update),
        .timeout_err   (timeout_err),
        .range_err     (range_err)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        hValid   = 1'b0;
        hSign    = 1'b0;
        hHund    = 1'b0;
        hTens    = 4'd0;
        hUnits   = 4'd0;
        hTenths  = 4'd0;
        hRaw     = 16'd0;
        hRange   = 1'b0;
        hTimeout = 1'b0;
    endtask

    task automatic waitStart(output int n);
        n = 0;
        for (int i = 1; i <= 4 * P && n == 0; i++) begin
            @(negedge clk);
            if (start) n = i;
        end
    endtask

    task automatic waitStartChk();
        int n;
        waitStart(n);
        check("start_arrives", 32'(n != 0), 1);
    endtask

    // Called at the negedge where start was seen.
    task automatic respond(input vec_t v);
        int          lat;
        int          nUpd;
        logic [13:0] cDig;
        logic [15:0] cRaw;
        logic [2:0]  cFlags;
        lat    = 0;
        nUpd   = 0;
        cDig   = '0;
        cRaw   = '0;
        cFlags = '0;
        @(negedge clk);
        check("start_one_cycle", start, 0);
        repeat (RESP - 1) @(negedge clk);
        temperature = v.raw;
        temp_strobe = 1'b1;
        for (int i = 1; i <= RESP; i++) begin
            @(negedge clk);
            if (i == 1) begin
                temp_strobe = 1'b0;
                temperature = 16'hDEAD;
            end
            if (temp_update) begin
                nUpd++;
                if (lat == 0) begin
                    lat    = i;
                    cDig   = {temp_sign, temp_hundreds, temp_tens,
                              temp_units, temp_tenths};
                    cRaw   = temp_raw;
                    cFlags = {temp_valid, timeout_err, range_err};
                end
            end
        end
        if (v.kind == K_OK) begin
            check("update_count", nUpd, 1);
            check("update_latency", lat, 32'(v.tens) + 4);
            check("digits", cDig,
                  {v.sign, v.hund, v.tens, v.units, v.tenths});
            check("raw_out", cRaw, v.raw);
            check("valid_noerr", cFlags, 3'b100);
            hValid   = 1'b1;
            hSign    = v.sign;
            hHund    = v.hund;
            hTens    = v.tens;
            hUnits   = v.units;
            hTenths  = v.tenths;
            hRaw     = v.raw;
            hRange   = 1'b0;
            hTimeout = 1'b0;
        end else begin
            if (v.kind == K_RNG) hRange = 1'b1;
            check("no_update", nUpd, 0);
            check("held_digits",
                  {temp_sign, temp_hundreds, temp_tens, temp_units,
                   temp_tenths},
                  {hSign, hHund, hTens, hUnits, hTenths});
            check("held_raw", temp_raw, hRaw);
            check("held_flags", {temp_valid, timeout_err, range_err},
                  {hValid, hTimeout, hRange});
        end
    endtask

    task automatic serve(input vec_t v);
        waitStartChk();
        respond(v);
    endtask

    initial begin
        int n;
        int cnt;
        vec_t v;

        vecs[0]  = '{16'h0550, K_DISC, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[1]  = '{16'h0550, K_OK,   1'b0, 1'b0, 4'd8, 4'd5, 4'd0};
        vecs[2]  = '{16'h0198, K_OK,   1'b0, 1'b0, 4'd2, 4'd5, 4'd5};
        vecs[3]  = '{16'hFF5E, K_OK,   1'b1, 1'b0, 4'd1, 4'd0, 4'd1};
        vecs[4]  = '{16'h07D0, K_OK,   1'b0, 1'b1, 4'd2, 4'd5, 4'd0};
        vecs[5]  = '{16'h07E0, K_RNG,  1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[6]  = '{16'hFC90, K_OK,   1'b1, 1'b0, 4'd5, 4'd5, 4'd0};
        vecs[7]  = '{16'hFC8F, K_RNG,  1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[8]  = '{16'h0008, K_OK,   1'b0, 1'b0, 4'd0, 4'd0, 4'd5};
        vecs[9]  = '{16'h000F, K_OK,   1'b0, 1'b0, 4'd0, 4'd0, 4'd9};
        vecs[10] = '{16'hFFFF, K_OK,   1'b1, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[11] = '{16'h0630, K_OK,   1'b0, 1'b0, 4'd9, 4'd9, 4'd0};
        vecs[12] = '{16'h0000, K_OK,   1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[13] = '{16'h0550, K_OK,   1'b0, 1'b0, 4'd8, 4'd5, 4'd0};

        reset       = 1'b1;
        enable      = 1'b1;
        temperature = 16'hDEAD;
        temp_strobe = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        check("reset_raw", temp_raw, 0);
        check("reset_flags",
              {start, temp_sign, temp_hundreds, temp_tens, temp_units,
               temp_tenths, temp_valid, temp_update, timeout_err,
               range_err}, 0);
        reset = 1'b0;
        waitStart(n);
        check("first_start_gap", n, P);
        respond(vecs[0]);

        for (int i = 1; i < 14; i++) begin
            serve(vecs[i]);
        end

        // Strobe while idle must be ignored.
        temperature = 16'h0123;
        temp_strobe = 1'b1;
        @(negedge clk);
        temp_strobe = 1'b0;
        temperature = 16'hDEAD;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (temp_update) cnt++;
        end
        check("idle_strobe_no_update", cnt, 0);
        check("idle_strobe_raw_held", temp_raw, hRaw);

        // Controller never answers.
        waitStartChk();
        for (int i = 1; i <= TO + 1; i++) begin
            @(negedge clk);
            if (i == TO) check("timeout_early", timeout_err, 0);
            if (i == TO + 1) check("timeout_set", timeout_err, 1);
        end
        hTimeout = 1'b1;
        check("timeout_holds_valid", temp_valid, 1);
        waitStart(n);
        check("timeout_restart_gap", n, P);
        check("timeout_sticky", timeout_err, 1);
        respond(vecs[2]);

        // Dropping enable mid-poll lets the poll finish, then stalls.
        waitStartChk();
        enable = 1'b0;
        respond(vecs[3]);
        cnt = 0;
        repeat (3 * P) begin
            @(negedge clk);
            if (start) cnt++;
        end
        check("no_start_disabled", cnt, 0);
        enable = 1'b1;
        waitStart(n);
        check("enable_gap", n, P);
        respond(vecs[4]);

        // Reset while the divider is stepping tens.
        waitStartChk();
        repeat (RESP) @(negedge clk);
        temperature = 16'h0630;
        temp_strobe = 1'b1;
        @(negedge clk);
        temp_strobe = 1'b0;
        temperature = 16'hDEAD;
        repeat (4) @(negedge clk);
        check("pre_reset_valid", temp_valid, 1);
        check("pre_reset_no_update", temp_update, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_raw", temp_raw, 0);
        check("midrun_reset_flags",
              {start, temp_sign, temp_hundreds, temp_tens, temp_units,
               temp_tenths, temp_valid, temp_update, timeout_err,
               range_err}, 0);
        reset = 1'b0;
        modelReset();
        waitStart(n);
        check("post_reset_gap", n, P);
        respond(vecs[0]);
        v = vecs[1];
        serve(v);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
